// File: rtl/linebuf_pkg.sv
// linebuf_pkg -- shared configuration for the streaming line buffer.
//
// Holds the default window side, pixel width, size-input width, maximum map
// side and the matching counter width, plus a small helper that maps a
// (row, column) window position onto the flat pixel_out index.
package linebuf_pkg;

  localparam int FSIZE  = 5;             // convolution window side
  localparam int DWIDTH = 16;            // signed pixel width
  localparam int LWIDTH = 10;            // width of the size configuration input
  localparam int MAXW   = 256;           // maximum map side / line-store depth
  localparam int CWIDTH = $clog2(MAXW);  // row / column counter width

  // Flat index of window entry (row, col): row-major, top-left first.
  function automatic int win_index(input int row, input int col, input int side);
    return row * side + col;
  endfunction

endpackage

// File: rtl/linebuf_mem.sv
// linebuf_mem -- one line store of the line buffer.
//
// Single write port, single read port, DEPTH x WIDTH. The read is
// combinational so the old contents of an address are available in the same
// cycle the new pixel is written there, which is what lets one store hand its
// row down to the next store while taking the newer row in.
// Contents are not reset; stale data is masked by the window-valid logic.
//
// Ports:
//   clk    - clock, writes on the rising edge
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational)
module linebuf_mem #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage array write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end else begin
      mem_r[waddr] <= mem_r[waddr];
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/linebuf.sv
// linebuf -- streaming line buffer producing FSIZE x FSIZE convolution windows.
//
// Pixels of a square w x w map arrive in raster order, one per cycle when
// buf_en is high. FSIZE-1 line stores keep the previous rows, addressed by
// the column counter, and an FSIZE x FSIZE shift register holds the window.
// A window is flagged valid one cycle after accepting pixel (r,c) with both
// r and c at least FSIZE-1; frame_done pulses one cycle after the last pixel.
//
// Build option: define LINEBUF_REG_OUT_EN to add one register stage on
// pixel_out, out_valid and frame_done (latency 2 instead of 1).
//
// Ports:
//   clk        - clock
//   xrst       - asynchronous active-high reset
//   buf_rst    - synchronous frame restart (wins over buf_en)
//   buf_en     - pixel_in valid this cycle
//   pixel_in   - streamed pixel, signed
//   w_fea_size - side of the square input map, 1..MAXW
//   pixel_out  - window, index i*FSIZE+j = row r-(FSIZE-1)+i, col c-(FSIZE-1)+j
//   out_valid  - pixel_out holds a complete window
//   frame_done - one-cycle pulse after the last pixel of a frame
module linebuf #(
  parameter int FSIZE  = linebuf_pkg::FSIZE,
  parameter int DWIDTH = linebuf_pkg::DWIDTH,
  parameter int LWIDTH = linebuf_pkg::LWIDTH,
  parameter int MAXW   = linebuf_pkg::MAXW
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     buf_rst,
  input  logic                     buf_en,
  input  logic signed [DWIDTH-1:0] pixel_in,
  input  logic [LWIDTH-1:0]        w_fea_size,
  output logic signed [DWIDTH-1:0] pixel_out [FSIZE*FSIZE],
  output logic                     out_valid,
  output logic                     frame_done
);

  import linebuf_pkg::*;

  localparam int CW  = $clog2(MAXW);
  localparam int NWIN = FSIZE * FSIZE;

  logic [CW-1:0]            col_r;
  logic [CW-1:0]            row_r;
  logic                     accept_s;
  logic [LWIDTH-1:0]        last_s;
  logic                     col_last_s;
  logic                     row_last_s;
  logic                     win_ok_s;
  logic                     ov1_r;
  logic                     fd1_r;

  logic signed [DWIDTH-1:0] ls_rd_s  [FSIZE-1];
  logic signed [DWIDTH-1:0] ls_wd_s  [FSIZE-1];
  logic signed [DWIDTH-1:0] col_new_s [FSIZE];
  logic signed [DWIDTH-1:0] win_r     [NWIN];
  logic signed [DWIDTH-1:0] win_nxt_s [NWIN];

  // buf_rst takes priority: a pixel presented together with it is dropped.
  assign accept_s = buf_en & ~buf_rst;

  // ">=" rather than "==" so a mid-frame size change can never strand the
  // counters beyond the wrap point.
  assign last_s     = w_fea_size - LWIDTH'(1);
  assign col_last_s = (LWIDTH'(col_r) >= last_s);
  assign row_last_s = (LWIDTH'(row_r) >= last_s);
  assign win_ok_s   = (col_r >= CW'(FSIZE - 1)) && (row_r >= CW'(FSIZE - 1));

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      col_r <= '0;
      row_r <= '0;
    end else if (buf_rst) begin
      col_r <= '0;
      row_r <= '0;
    end else if (buf_en) begin
      if (col_last_s) begin
        col_r <= '0;
        if (row_last_s) begin
          row_r <= '0;
        end else begin
          row_r <= row_r + CW'(1);
        end
      end else begin
        col_r <= col_r + CW'(1);
        row_r <= row_r;
      end
    end else begin
      col_r <= col_r;
      row_r <= row_r;
    end
  end

  // Window-valid and end-of-frame flags; both drop on any non-accept cycle.
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      ov1_r <= 1'b0;
      fd1_r <= 1'b0;
    end else begin
      ov1_r <= accept_s & win_ok_s;
      fd1_r <= accept_s & col_last_s & row_last_s;
    end
  end

  // Line stores form a chain: store 0 holds row r-1, store k holds row r-1-k.
  // At each column the incoming pixel goes into store 0 while every store
  // passes its old entry one store further down.
  for (genvar gk = 0; gk < FSIZE - 1; gk++) begin : g_ls
    if (gk == 0) begin : g_head
      assign ls_wd_s[gk] = pixel_in;
    end else begin : g_chain
      assign ls_wd_s[gk] = ls_rd_s[gk-1];
    end

    linebuf_mem #(
      .DEPTH (MAXW),
      .WIDTH (DWIDTH),
      .AW    (CW)
    ) u_mem (
      .clk   (clk),
      .we    (accept_s),
      .waddr (col_r),
      .wdata (ls_wd_s[gk]),
      .raddr (col_r),
      .rdata (ls_rd_s[gk])
    );
  end

  // New right-hand column: oldest row at the top, live pixel at the bottom.
  for (genvar gi = 0; gi < FSIZE; gi++) begin : g_col
    if (gi == FSIZE - 1) begin : g_live
      assign col_new_s[gi] = pixel_in;
    end else begin : g_stored
      assign col_new_s[gi] = ls_rd_s[FSIZE-2-gi];
    end
  end

  for (genvar gi = 0; gi < FSIZE; gi++) begin : g_row
    for (genvar gj = 0; gj < FSIZE; gj++) begin : g_cell
      localparam int K = win_index(gi, gj, FSIZE);

      if (gj == FSIZE - 1) begin : g_load
        assign win_nxt_s[K] = col_new_s[gi];
      end else begin : g_shift
        assign win_nxt_s[K] = win_r[K+1];
      end

      // Window cell: shifts left on each accepted pixel, otherwise holds.
      always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
          win_r[K] <= '0;
        end else if (accept_s) begin
          win_r[K] <= win_nxt_s[K];
        end else begin
          win_r[K] <= win_r[K];
        end
      end

`ifdef LINEBUF_REG_OUT_EN
      logic signed [DWIDTH-1:0] out_cell_r;

      // Output stage cell: copies the window every cycle, so it holds
      // whenever the window itself holds.
      always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
          out_cell_r <= '0;
        end else begin
          out_cell_r <= win_r[K];
        end
      end

      assign pixel_out[K] = out_cell_r;
`else
      assign pixel_out[K] = win_r[K];
`endif
    end
  end

`ifdef LINEBUF_REG_OUT_EN
  logic ov2_r;
  logic fd2_r;

  // Output stage flags; a frame restart also discards the in-flight flags.
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      ov2_r <= 1'b0;
      fd2_r <= 1'b0;
    end else if (buf_rst) begin
      ov2_r <= 1'b0;
      fd2_r <= 1'b0;
    end else begin
      ov2_r <= ov1_r;
      fd2_r <= fd1_r;
    end
  end

  assign out_valid  = ov2_r;
  assign frame_done = fd2_r;
`else
  assign out_valid  = ov1_r;
  assign frame_done = fd1_r;
`endif

endmodule

// File: tb/tb_linebuf.sv
// tb_linebuf -- self-checking bench for linebuf (FSIZE=5, DWIDTH=16).
// Expected windows are computed from a bench-side image of the frame and
// queued when the pixel is driven; they are popped when out_valid rises.
module tb_linebuf;

  localparam int FS = 5;
  localparam int DW = 16;
  localparam int LW = 10;
  localparam int MW = 256;
  localparam int NW = FS * FS;
`ifdef LINEBUF_REG_OUT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef logic [NW*DW-1:0] winp_t;

  logic                 clk = 1'b0;
  logic                 xrst;
  logic                 buf_rst;
  logic                 buf_en;
  logic signed [DW-1:0] pixel_in;
  logic [LW-1:0]        w_fea_size;
  logic signed [DW-1:0] pixel_out [NW];
  logic                 out_valid;
  logic                 frame_done;

  always #5 clk = ~clk;

  linebuf #(.FSIZE(FS), .DWIDTH(DW), .LWIDTH(LW), .MAXW(MW)) dut (
    .clk        (clk),
    .xrst       (xrst),
    .buf_rst    (buf_rst),
    .buf_en     (buf_en),
    .pixel_in   (pixel_in),
    .w_fea_size (w_fea_size),
    .pixel_out  (pixel_out),
    .out_valid  (out_valid),
    .frame_done (frame_done)
  );

  int    n_vec = 0;
  int    n_err = 0;
  winp_t sb_q[$];
  logic signed [DW-1:0] img [16][16];
  int    mr, mc, w;
  logic  d1_v, d1_fd, d1_acc;
  logic  hold_ok;
  winp_t hold_win, first_obs, last_obs;
  int    n_ov_seen, n_fd_seen;

  function automatic winp_t pack_out();
    winp_t p;
    for (int k = 0; k < NW; k++) p[k*DW +: DW] = pixel_out[k];
    return p;
  endfunction

  task automatic model_clear();
    mr = 0; mc = 0;
    sb_q.delete();
    d1_v = 1'b0; d1_fd = 1'b0; d1_acc = 1'b0;
    hold_ok = 1'b0;
  endtask

  task automatic set_size(input int ww);
    w = ww;
    w_fea_size = LW'(ww);
    n_ov_seen = 0;
    n_fd_seen = 0;
  endtask

  // One clock of stimulus followed by model update and output checks.
  task automatic step(input logic en, input logic rs, input int val);
    winp_t ew, obs;
    logic  v_now, fd_now, acc_now, exp_ov, exp_fd, eff_acc;
    buf_en = en; buf_rst = rs; pixel_in = val[DW-1:0];
    @(posedge clk); #1;
    v_now = 1'b0; fd_now = 1'b0; acc_now = en && !rs;
    if (rs) begin
      mr = 0; mc = 0;
      if (LAT == 2 && d1_v) void'(sb_q.pop_back());
      d1_v = 1'b0; d1_fd = 1'b0;
    end else if (en) begin
      img[mr][mc] = val[DW-1:0];
      if (mr >= FS-1 && mc >= FS-1) begin
        v_now = 1'b1;
        for (int i = 0; i < FS; i++)
          for (int j = 0; j < FS; j++)
            ew[(i*FS+j)*DW +: DW] = img[mr-FS+1+i][mc-FS+1+j];
        sb_q.push_back(ew);
      end
      fd_now = (mr == w-1 && mc == w-1);
      if (mc >= w-1) begin
        mc = 0;
        mr = (mr >= w-1) ? 0 : mr + 1;
      end else begin
        mc = mc + 1;
      end
    end
    if (LAT == 1) begin
      exp_ov = v_now; exp_fd = fd_now; eff_acc = acc_now;
    end else begin
      exp_ov = d1_v; exp_fd = d1_fd; eff_acc = d1_acc;
    end
    d1_v = v_now; d1_fd = fd_now; d1_acc = acc_now;

    n_vec++;
    if (out_valid !== exp_ov) begin
      n_err++; $display("FAIL out_valid: got %b want %b at %0t", out_valid, exp_ov, $time);
    end
    n_vec++;
    if (frame_done !== exp_fd) begin
      n_err++; $display("FAIL frame_done: got %b want %b at %0t", frame_done, exp_fd, $time);
    end
    obs = pack_out();
    if (out_valid === 1'b1) begin
      n_ov_seen++;
      if (n_ov_seen == 1) first_obs = obs;
      last_obs = obs;
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++; $display("FAIL window: got unexpected window %h, want none queued at %0t", obs, $time);
      end else begin
        ew = sb_q.pop_front();
        if (obs !== ew) begin
          n_err++; $display("FAIL window: got %h want %h at %0t", obs, ew, $time);
        end
      end
      hold_ok = 1'b1; hold_win = obs;
    end else if (eff_acc) begin
      hold_ok = 1'b0;
    end else if (hold_ok) begin
      n_vec++;
      if (obs !== hold_win) begin
        n_err++; $display("FAIL hold: got %h want %h at %0t", obs, hold_win, $time);
      end
    end
    if (frame_done === 1'b1) n_fd_seen++;
  endtask

  task automatic feed(input int npix, input int base, input int max_gap);
    for (int k = 0; k < npix; k++) begin
      int g;
      g = $urandom_range(0, max_gap);
      for (int q = 0; q < g; q++) step(1'b0, 1'b0, 0);
      step(1'b1, 1'b0, base + k);
    end
  endtask

  task automatic flush();
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++; $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    n_vec++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0 || pack_out() !== '0) begin
      n_err++;
      $display("FAIL %s: got ov=%b fd=%b win=%h want all zero", name, out_valid, frame_done, pack_out());
    end
  endtask

  task automatic test_reset();
    xrst = 1'b1; buf_rst = 1'b0; buf_en = 1'b0; pixel_in = '0; w_fea_size = LW'(5);
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    xrst = 1'b0;
    model_clear();
  endtask

  task automatic test_single_window();
    winp_t kw;
    for (int k = 0; k < NW; k++) kw[k*DW +: DW] = DW'(k);
    set_size(5);
    feed(25, 0, 0);
    flush();
    check_int("w5_windows", n_ov_seen, 1);
    check_int("w5_frame_done", n_fd_seen, 1);
    n_vec++;
    if (first_obs !== kw) begin
      n_err++; $display("FAIL w5_ramp: got %h want %h", first_obs, kw);
    end
  endtask

  task automatic check_ramp8(input string name, input int base);
    check_int({name, "_windows"}, n_ov_seen, 16);
    check_int({name, "_frame_done"}, n_fd_seen, 1);
    check_int({name, "_first0"},  int'(signed'(first_obs[0 +: DW])), base + 0);
    check_int({name, "_first24"}, int'(signed'(first_obs[24*DW +: DW])), base + 36);
    check_int({name, "_last0"},   int'(signed'(last_obs[0 +: DW])), base + 27);
    check_int({name, "_last24"},  int'(signed'(last_obs[24*DW +: DW])), base + 63);
  endtask

  task automatic test_ramp8();
    set_size(8);
    feed(64, 0, 0);
    flush();
    check_ramp8("w8", 0);
  endtask

  task automatic test_gaps();
    set_size(8);
    feed(64, 0, 3);
    flush();
    check_ramp8("w8_gaps", 0);
  endtask

  task automatic test_buf_rst();
    set_size(8);
    feed(20, 200, 0);
    step(1'b1, 1'b1, 999);
    n_ov_seen = 0; n_fd_seen = 0;
    feed(64, 500, 1);
    flush();
    check_ramp8("buf_rst", 500);
  endtask

  task automatic test_xrst();
    set_size(8);
    feed(40, 300, 0);
    xrst = 1'b1;
    #1;
    check_zero_outputs("xrst_async");
    @(posedge clk); #1;
    xrst = 1'b0;
    model_clear();
    n_ov_seen = 0; n_fd_seen = 0;
    feed(64, 1000, 0);
    flush();
    check_ramp8("after_xrst", 1000);
  endtask

  task automatic test_small();
    set_size(3);
    feed(9, 40, 1);
    flush();
    check_int("w3_windows", n_ov_seen, 0);
    check_int("w3_frame_done", n_fd_seen, 1);
    set_size(1);
    feed(3, -7, 0);
    flush();
    check_int("w1_windows", n_ov_seen, 0);
    check_int("w1_frame_done", n_fd_seen, 3);
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_ramp8();
    test_gaps();
    test_buf_rst();
    test_xrst();
    test_small();
    check_int("queue_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
